// File: rtl/fr.sv
// Flags register: WIDTH ALU condition flags captured on clk rise when load_bar is low,
// cleared asynchronously by reset. out comes straight from the flops.

module fr_bit (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic load_bar,
  output logic q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         q <= 1'b0;
    else if (!load_bar) q <= d;
  end
endmodule

module fr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load_bar,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] q;

  // Every bit shares the same strobe, so all flags are captured together.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fr_bit u_bit (
      .clk      (clk),
      .reset    (reset),
      .d        (in[i]),
      .load_bar (load_bar),
      .q        (q[i])
    );
  end

  assign out = q;
endmodule

// File: tb/tb_fr.sv
// Directed checks of fr at WIDTH=3 and WIDTH=8; clk is driven by hand so edges
// can be placed exactly where each step needs them.

module tb_fr;
  logic       clk, reset;
  logic [2:0] in3;
  logic       lb3;
  logic [2:0] out3;
  logic [7:0] in8;
  logic       lb8;
  logic [7:0] out8;
  int total = 0;
  int bad   = 0;

  fr #(.WIDTH(3)) u3 (.clk(clk), .reset(reset), .in(in3), .load_bar(lb3), .out(out3));
  fr #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .in(in8), .load_bar(lb8), .out(out8));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 0; reset = 0; in3 = 3'b000; lb3 = 1; in8 = 8'h00; lb8 = 1;
    #5;
    // reset pulse with a pending load and clk held low
    in3 = 3'b111; lb3 = 0; reset = 1; #2;
    check("rst_during", {5'b0, out3}, 8'h00);
    check("rst8_during", out8, 8'h00);
    reset = 0; #2;
    check("rst_after", {5'b0, out3}, 8'h00);
    clk = 1; #2;
    check("first_load", {5'b0, out3}, 8'h07);

    // no load without an edge
    clk = 0; #2; reset = 1; #2; reset = 0; #2;
    check("rst2", {5'b0, out3}, 8'h00);
    in3 = 3'b101; lb3 = 1; #2;
    check("in_change_no_edge", {5'b0, out3}, 8'h00);
    lb3 = 0; #2;
    check("lb_fall_no_edge", {5'b0, out3}, 8'h00);
    clk = 1; #2;
    check("load_101", {5'b0, out3}, 8'h05);

    // hold
    clk = 0; in3 = 3'b000; lb3 = 1; #2;
    check("hold_pre", {5'b0, out3}, 8'h05);
    clk = 1; #2;
    check("hold_rise", {5'b0, out3}, 8'h05);
    clk = 0; #2;
    check("hold_fall", {5'b0, out3}, 8'h05);

    // reload zeros
    lb3 = 0; #2; clk = 1; #2;
    check("reload_0", {5'b0, out3}, 8'h00);

    // reset priority over toggling clock
    clk = 0; in3 = 3'b110; lb3 = 0; reset = 1; #2;
    check("prio_start", {5'b0, out3}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      clk = 1; #2;
      check("prio_rise", {5'b0, out3}, 8'h00);
      clk = 0; #2;
      check("prio_fall", {5'b0, out3}, 8'h00);
    end
    reset = 0; #2;
    check("prio_release", {5'b0, out3}, 8'h00);
    clk = 1; #2;
    check("load_110", {5'b0, out3}, 8'h06);

    // width 8: load A5 then hold through three edges while in changes
    clk = 0; in8 = 8'hA5; lb8 = 0; #2;
    check("w8_pre", out8, 8'h00);
    clk = 1; #2;
    check("w8_load", out8, 8'hA5);
    lb8 = 1; in8 = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      clk = 0; #2; clk = 1; #2;
      check("w8_hold", out8, 8'hA5);
    end

    // asynchronous clear while clk is high, no edge involved
    lb3 = 1; reset = 1; #1;
    check("async_clr3", {5'b0, out3}, 8'h00);
    check("async_clr8", out8, 8'h00);
    clk = 0; #2; reset = 0; #2;
    check("post_clr_hold", {5'b0, out3}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
